// File: rtl/y86_mem_pkg.sv
// y86_mem_pkg
// Shared definitions for the Y86 data-memory arbiter slice:
//   DEPTH / AW  : memory geometry (64-bit words, index width)
//   resp_st_t   : response-routing state of the arbiter
//   ICODE_*     : Y86 instruction codes whose traffic reaches the memory stage
package y86_mem_pkg;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned AW    = 8;

   typedef enum logic [2:0] {
      NONE,
      F_RD,
      D_RD,
      D_WR,
      ERR_F,
      ERR_D
   } resp_st_t;

   localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
   localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
   localparam logic [3:0] ICODE_CALL   = 4'h8;
   localparam logic [3:0] ICODE_RET    = 4'h9;
   localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
   localparam logic [3:0] ICODE_POPQ   = 4'hB;

endpackage

// File: rtl/y86_mem_array.sv
// y86_mem_array
// Single-port DEPTH x W memory, synchronous write, registered read.
// Contents are not reset.
//   clk   : rising-edge clock
//   en    : access enable for this cycle
//   we    : 1 = write wdata at addr, 0 = read addr into rdata
//   addr  : word index
//   wdata : write data
//   rdata : read data, valid the cycle after a read access
module y86_mem_array
   import y86_mem_pkg::*;
#(
   parameter int unsigned DEPTH = y86_mem_pkg::DEPTH,
   parameter int unsigned AW    = y86_mem_pkg::AW,
   parameter int unsigned W     = 64
)(
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   // rdata holds its value on writes and idle cycles; the arbiter only
   // forwards it in cycles that follow a read.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/y86_mem_arbiter.sv
// y86_mem_arbiter
// Shares the single-port Y86 data memory between fetch (read-only) and the
// memory stage (read/write). Data wins by default; a starvation counter
// forces a fetch grant after STARVE_MAX consecutive denials. Every access is
// range-checked: out-of-range requests are accepted but touch no memory and
// answer with err=1, rdata=0, and set the sticky mem_error.
//   clk, rst_n                : clock, async active-low reset
//   f_req/f_addr/f_ready      : fetch request handshake
//   f_rvalid/f_rdata/f_err    : fetch response, one cycle after acceptance
//   d_req/d_we/d_addr/d_wdata : data request
//   d_ready                   : data request accepted this cycle
//   d_rvalid/d_rdata/d_err    : data response (reads and writes)
//   mem_error                 : sticky out-of-range flag
//   busy                      : a response is being presented this cycle
module y86_mem_arbiter
   import y86_mem_pkg::*;
#(
   parameter int unsigned DEPTH      = y86_mem_pkg::DEPTH,
   parameter int unsigned AW         = y86_mem_pkg::AW,
   parameter int unsigned STARVE_MAX = 3
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        f_req,
   input  logic [63:0] f_addr,
   output logic        f_ready,
   output logic        f_rvalid,
   output logic [63:0] f_rdata,
   output logic        f_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [63:0] d_addr,
   input  logic [63:0] d_wdata,
   output logic        d_ready,
   output logic        d_rvalid,
   output logic [63:0] d_rdata,
   output logic        d_err,
   output logic        mem_error,
   output logic        busy
);

   localparam int unsigned     SW   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [63:0]     LAST = 64'(DEPTH - 1);
   localparam logic [SW-1:0]   SMAX = SW'(STARVE_MAX);

   resp_st_t      resp_st;
   resp_st_t      resp_nx;
   logic [SW-1:0] starve_cnt;
   logic          f_win;
   logic          f_oor;
   logic          d_oor;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [63:0]   mem_rdata;

   always_comb begin
      f_oor = f_addr > LAST;
      d_oor = d_addr > LAST;

      // Both readies include their own req, so a grant is simply ready.
      f_win   = f_req && (!d_req || (starve_cnt == SMAX));
      f_ready = rst_n && f_win;
      d_ready = rst_n && d_req && !f_win;

      mem_en   = (f_ready && !f_oor) || (d_ready && !d_oor);
      mem_we   = d_ready && d_we && !d_oor;
      mem_addr = f_ready ? f_addr[AW-1:0] : d_addr[AW-1:0];

      resp_nx = NONE;
      if (f_ready) begin
         resp_nx = f_oor ? ERR_F : F_RD;
      end else if (d_ready) begin
         if (d_oor) begin
            resp_nx = ERR_D;
         end else begin
            resp_nx = d_we ? D_WR : D_RD;
         end
      end
   end

   // Flag outputs are registered alongside resp_st from the same next-state
   // decode, so they always agree with the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_st    <= NONE;
         starve_cnt <= '0;
         f_rvalid   <= 1'b0;
         f_err      <= 1'b0;
         d_rvalid   <= 1'b0;
         d_err      <= 1'b0;
         busy       <= 1'b0;
         mem_error  <= 1'b0;
      end else begin
         resp_st   <= resp_nx;
         f_rvalid  <= (resp_nx == F_RD) || (resp_nx == ERR_F);
         f_err     <= (resp_nx == ERR_F);
         d_rvalid  <= (resp_nx == D_RD) || (resp_nx == D_WR) || (resp_nx == ERR_D);
         d_err     <= (resp_nx == ERR_D);
         busy      <= (resp_nx != NONE);
         mem_error <= mem_error || (f_ready && f_oor) || (d_ready && d_oor);

         if (!f_req || f_ready) begin
            starve_cnt <= '0;
         end else if (starve_cnt != SMAX) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

   // Read data is gated by state so writes, errors and reset never expose
   // the array register (which may hold stale or X data).
   always_comb begin
      f_rdata = (resp_st == F_RD) ? mem_rdata : '0;
      d_rdata = (resp_st == D_RD) ? mem_rdata : '0;
   end

   y86_mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (64)
   ) u_array (
      .clk   (clk),
      .en    (mem_en),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (d_wdata),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// tb_y86_mem_arbiter
// Self-checking bench for y86_mem_arbiter: table of request vectors with the
// hand-derived grant per cycle, a memory model producing expected responses
// into a scoreboard queue, plus hand-written starvation and reset sequences.
module tb_y86_mem_arbiter;

   localparam logic [7:0] G_N = "N";
   localparam logic [7:0] G_D = "D";
   localparam logic [7:0] G_F = "F";

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        f_req = 1'b0;
   logic [63:0] f_addr = '0;
   logic        f_ready;
   logic        f_rvalid;
   logic [63:0] f_rdata;
   logic        f_err;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [63:0] d_addr = '0;
   logic [63:0] d_wdata = '0;
   logic        d_ready;
   logic        d_rvalid;
   logic [63:0] d_rdata;
   logic        d_err;
   logic        mem_error;
   logic        busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          f_req;
      logic [63:0] f_addr;
      bit          d_req;
      bit          d_we;
      logic [63:0] d_addr;
      logic [63:0] d_wdata;
      logic [7:0]  g;       // expected grant: N, D or F
   } vec_t;

   typedef struct {
      logic [7:0]  g;
      bit          err;
      logic [63:0] rdata;
      bit          dc;      // read of a never-written word: data not compared
   } resp_t;

   resp_t       sb[$];
   logic [63:0] mem_m [256];
   bit          mem_v [256];
   bit          err_m = 1'b0;
   vec_t        vt [20];

   y86_mem_arbiter #(
      .DEPTH      (256),
      .AW         (8),
      .STARVE_MAX (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .f_req     (f_req),
      .f_addr    (f_addr),
      .f_ready   (f_ready),
      .f_rvalid  (f_rvalid),
      .f_rdata   (f_rdata),
      .f_err     (f_err),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ready   (d_ready),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .d_err     (d_err),
      .mem_error (mem_error),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input bit fr, input logic [63:0] fa, input bit dr,
                               input bit dw, input logic [63:0] da,
                               input logic [63:0] dd, input logic [7:0] g);
      vec_t v;
      v.f_req = fr; v.f_addr = fa; v.d_req = dr; v.d_we = dw;
      v.d_addr = da; v.d_wdata = dd; v.g = g;
      return v;
   endfunction

   // Called at posedge+1: drive, check readies, push expected response,
   // cross the edge, pop and compare the response.
   task automatic apply(input vec_t v);
      resp_t       r;
      logic [63:0] a;
      bit          oor;
      f_req = v.f_req; f_addr = v.f_addr;
      d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
      #1;
      chk("f_ready", 64'(f_ready), 64'(v.g == G_F));
      chk("d_ready", 64'(d_ready), 64'(v.g == G_D));
      r.g = v.g; r.err = 1'b0; r.rdata = '0; r.dc = 1'b0;
      a = (v.g == G_F) ? v.f_addr : v.d_addr;
      oor = a > 64'd255;
      if (v.g != G_N) begin
         r.err = oor;
         if (oor) begin
            err_m = 1'b1;
         end else if (v.g == G_D && v.d_we) begin
            mem_m[a[7:0]] = v.d_wdata;
            mem_v[a[7:0]] = 1'b1;
         end else begin
            r.rdata = mem_m[a[7:0]];
            r.dc    = !mem_v[a[7:0]];
         end
      end
      sb.push_back(r);
      @(posedge clk);
      #1;
      r = sb.pop_front();
      chk("f_rvalid", 64'(f_rvalid), 64'(r.g == G_F));
      chk("f_err", 64'(f_err), 64'(r.g == G_F && r.err));
      chk("d_rvalid", 64'(d_rvalid), 64'(r.g == G_D));
      chk("d_err", 64'(d_err), 64'(r.g == G_D && r.err));
      chk("busy", 64'(busy), 64'(r.g != G_N));
      chk("mem_error", 64'(mem_error), 64'(err_m));
      if (!r.dc) begin
         chk("f_rdata", f_rdata, (r.g == G_F) ? r.rdata : 64'd0);
         chk("d_rdata", d_rdata, (r.g == G_D) ? r.rdata : 64'd0);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_f_ready"}, 64'(f_ready), 64'd0);
      chk({nm, "_d_ready"}, 64'(d_ready), 64'd0);
      chk({nm, "_f_rvalid"}, 64'(f_rvalid), 64'd0);
      chk({nm, "_d_rvalid"}, 64'(d_rvalid), 64'd0);
      chk({nm, "_f_rdata"}, f_rdata, 64'd0);
      chk({nm, "_d_rdata"}, d_rdata, 64'd0);
      chk({nm, "_f_err"}, 64'(f_err), 64'd0);
      chk({nm, "_d_err"}, 64'(d_err), 64'd0);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_mem_error"}, 64'(mem_error), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_m[i] = '0;
         mem_v[i] = 1'b0;
      end

      // Grants derived by hand: data wins, fetch forced after 3 denials.
      vt[0]  = mk(0, 64'h0,  1, 1, 64'h10,  64'hDEADBEEF, G_D);
      vt[1]  = mk(0, 64'h0,  1, 0, 64'h10,  64'h0,        G_D);
      vt[2]  = mk(1, 64'h10, 0, 0, 64'h0,   64'h0,        G_F);
      vt[3]  = mk(0, 64'h0,  1, 1, 64'h7,   64'h5,        G_D);
      vt[4]  = mk(1, 64'h7,  0, 0, 64'h0,   64'h0,        G_F);
      vt[5]  = mk(0, 64'h0,  1, 1, 64'h0,   64'h1234,     G_D);
      vt[6]  = mk(0, 64'h0,  1, 1, 64'd256, 64'hBAD,      G_D);
      vt[7]  = mk(0, 64'h0,  1, 0, 64'h0,   64'h0,        G_D);
      vt[8]  = mk(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64'h0, 64'h0, G_F);
      vt[9]  = mk(0, 64'h0,  1, 1, 64'd255, 64'hAA,       G_D);
      vt[10] = mk(1, 64'd255, 0, 0, 64'h0,  64'h0,        G_F);
      vt[11] = mk(1, 64'h10, 1, 0, 64'h7,   64'h0,        G_D);
      vt[12] = mk(1, 64'h10, 1, 0, 64'h10,  64'h0,        G_D);
      vt[13] = mk(1, 64'h10, 1, 0, 64'h7,   64'h0,        G_D);
      vt[14] = mk(1, 64'h10, 1, 0, 64'h7,   64'h0,        G_F);
      vt[15] = mk(0, 64'h0,  0, 0, 64'h0,   64'h0,        G_N);
      vt[16] = mk(1, 64'h0,  1, 0, 64'h7,   64'h0,        G_D);
      vt[17] = mk(0, 64'h0,  1, 0, 64'h10,  64'h0,        G_D);
      vt[18] = mk(1, 64'h0,  1, 0, 64'h7,   64'h0,        G_D);
      vt[19] = mk(0, 64'h0,  0, 0, 64'h0,   64'h0,        G_N);

      // Reset state with both requests asserted: readies must stay low.
      f_req = 1'b1; d_req = 1'b1;
      #12;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vt[i]) apply(vt[i]);

      // Continuous contention: D,D,D,F repeating.
      for (int i = 0; i < 12; i++) begin
         apply(mk(1, 64'h10, 1, 0, 64'h7, 64'h0, (i % 4 == 3) ? G_F : G_D));
      end

      // Reset right after a read is accepted.
      f_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h10;
      #1;
      chk("rst_seq_d_ready", 64'(d_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      f_req = 1'b1;
      #1;
      chk_all_zero("async_rst");
      @(posedge clk);
      #1;
      chk_all_zero("held_rst");
      rst_n = 1'b1;
      sb.delete();
      err_m = 1'b0;
      apply(mk(0, 64'h0, 0, 0, 64'h0, 64'h0, G_N));
      apply(mk(0, 64'h0, 1, 0, 64'h10, 64'h0, G_D));
      apply(mk(1, 64'h0, 0, 0, 64'h0, 64'h0, G_F));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
